// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// One shift-add or restoring shift-subtract step per cycle; sign fix-up in FIN.
//
// state  | meaning
// IDLE   | waiting for Start; MTHI/MTLO writes accepted
// CALC   | one multiply/divide iteration per cycle, WIDTH cycles
// FIN    | sign correction, hi/lo commit, Done pulse
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       MdOp,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             HiWre,
  input  logic             LoWre,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam int            CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  logic [1:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic               r_sa;
  logic               r_sb;
  logic               r_dz;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo_mag;
  logic [WIDTH-1:0]   w_rem_mag;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  // MdOp[0] clear selects the signed variants
  assign w_neg_a = ~MdOp[0] & src_a[WIDTH-1];
  assign w_neg_b = ~MdOp[0] & src_b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -src_a : src_a;
  assign w_mag_b = w_neg_b ? -src_b : src_b;

  // multiply: add multiplicand into the upper half on LSB, then shift right with carry
  assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_add, r_acc[WIDTH-1:1]};

  // divide: upper half is the partial remainder, lower half shifts dividend out / quotient in
  assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_opnd});
  assign w_diff     = w_shift - {1'b0, r_opnd};
  assign w_div_next = {(w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};

  assign w_prod    = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_quo_mag = r_acc[WIDTH-1:0];
  assign w_rem_mag = r_acc[2*WIDTH-1:WIDTH];
  assign w_quo     = (r_sa ^ r_sb) ? -w_quo_mag : w_quo_mag;
  assign w_rem     = r_sa ? -w_rem_mag : w_rem_mag;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_dz     <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_is_div <= MdOp[1];
            r_sa     <= w_neg_a;
            r_sb     <= w_neg_b;
            r_dz     <= (src_b == '0);
            r_opnd   <= MdOp[1] ? w_mag_b : w_mag_a;
            r_acc    <= {{WIDTH{1'b0}}, (MdOp[1] ? w_mag_a : w_mag_b)};
            r_cnt    <= C_LOAD;
            r_state  <= S_CALC;
          end else begin
            if (HiWre) r_hi <= src_a;
            if (LoWre) r_lo <= src_a;
          end
        end
        S_CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - C_ONE;
          if (r_cnt == C_ONE) r_state <= S_FIN;
        end
        S_FIN: begin
          if (r_is_div) begin
            // a zero divisor leaves the dividend in the remainder; quotient forced to all ones
            r_hi <= w_rem;
            r_lo <= r_dz ? '1 : w_quo;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy = (r_state != S_IDLE);
  assign Done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected hi/lo queued at Start, compared on Done.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        Reset, Start, HiWre, LoWre;
  logic [1:0]  MdOp;
  logic [31:0] src_a, src_b;
  logic        Busy, Done;
  logic [31:0] hi, lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .Reset(Reset), .Start(Start), .MdOp(MdOp),
    .src_a(src_a), .src_b(src_b), .HiWre(HiWre), .LoWre(LoWre),
    .Busy(Busy), .Done(Done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // result side of the scoreboard
  always @(negedge clk) begin
    if (Done === 1'b1) begin
      exp_t e;
      check("done_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("result_hi", 64'(hi), 64'(e.hi));
        check("result_lo", 64'(lo), 64'(e.lo));
      end
    end
  end

  // drives Start on a negedge, optionally with LoWre, optionally disturbed mid-CALC
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el,
                       input logic lowre, input logic disturb);
    int cyc;
    int busy;
    Start = 1'b1; MdOp = op; src_a = a; src_b = b; LoWre = lowre;
    sb_q.push_back('{hi: eh, lo: el});
    @(negedge clk);
    Start = 1'b0; LoWre = 1'b0; src_a = $urandom; src_b = $urandom; MdOp = 2'($urandom);
    check("done_one_cycle", 64'(Done), 64'd0);
    check("hold_hi", 64'(hi), 64'(m_hi));
    check("hold_lo", 64'(lo), 64'(m_lo));
    cyc  = 1;
    busy = (Busy === 1'b1) ? 1 : 0;
    while (Done !== 1'b1 && cyc < 100) begin
      if (disturb && cyc == 5) begin
        Start = 1'b1; HiWre = 1'b1; LoWre = 1'b1; src_a = 32'hDEADBEEF; MdOp = OP_MULTU;
      end else begin
        Start = 1'b0; HiWre = 1'b0; LoWre = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (Busy === 1'b1) busy++;
      if (cyc == 20) check("stale_hi", 64'(hi), 64'(m_hi));
    end
    Start = 1'b0; HiWre = 1'b0; LoWre = 1'b0;
    check("latency", 64'(cyc), 64'd34);
    check("busy_cycles", 64'(busy), 64'd33);
    m_hi = eh; m_lo = el;
  endtask

  initial begin
    int dones;
    Reset = 1'b1; Start = 1'b0; HiWre = 1'b0; LoWre = 1'b0;
    MdOp = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    @(negedge clk);

    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
    do_op(OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
    do_op(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
    do_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    do_op(OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0);
    do_op(OP_DIVU,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
    do_op(OP_DIV,   32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h80000001, 1'b0, 1'b0);
    do_op(OP_DIVU,  32'd1000,     32'd3,        32'd1,        32'd333,      1'b0, 1'b1);

    // MTHI alone, then both writes together
    HiWre = 1'b1; src_a = 32'hDEADBEEF;
    @(negedge clk);
    HiWre = 1'b0;
    check("mthi_hi", 64'(hi), 64'hDEADBEEF);
    check("mthi_lo", 64'(lo), 64'(m_lo));
    m_hi = 32'hDEADBEEF;
    HiWre = 1'b1; LoWre = 1'b1; src_a = 32'h0000_55AA;
    @(negedge clk);
    HiWre = 1'b0; LoWre = 1'b0;
    check("mthilo_hi", 64'(hi), 64'h55AA);
    check("mthilo_lo", 64'(lo), 64'h55AA);
    m_hi = 32'h55AA; m_lo = 32'h55AA;

    // LoWre in the Start cycle must be dropped (src_a = 2 would otherwise land in lo)
    do_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b1, 1'b0);

    // abort at cycle 10: no push, so any Done would trip the scoreboard
    Start = 1'b1; MdOp = OP_MULTU; src_a = 32'd5; src_b = 32'd5;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_busy", 64'(Busy), 64'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done === 1'b1) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    m_hi = '0; m_lo = '0;

    do_op(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0);
    @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit for the single-cycle CPU. It sits directly downstream of the register file:
- Consumes the two register read ports (rs on src_a, rt on src_b).
- Produces the architectural HI/LO pair, which the write-back mux routes into the register file's write_data for mfhi/mflo.

It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO. The control unit stalls the PC while Busy is high.

## Interface
- WIDTH, 32, operand width; the iteration count equals WIDTH. Only 32 is required for sign-off.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  launch the operation selected by MdOp; sampled only in IDLE.
- MdOp  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  in  WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO data.
- src_b  in  WIDTH  rt value: multiplier or divisor.
- HiWre  in  1  MTHI: hi <= src_a.
- LoWre  in  1  MTLO: lo <= src_a.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse when hi/lo hold a new result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- FSM states: IDLE, CALC, FIN.
- **IDLE + Start:**
  - Latch operand magnitudes. For MULT/DIV, negative operands are two's-complement negated and their sign flags recorded. For MULTU/DIVU, sign flags are 0.
  - Load the iteration counter with WIDTH; go to CALC.
- **CALC:**
  - One iteration per cycle.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, giving a WIDTH-bit remainder and WIDTH-bit quotient.
  - Counter decrements each cycle; after WIDTH iterations go to FIN.
- **FIN:**
  - Apply sign correction. Product is negated if sa^sb. Quotient is negated if sa^sb. Remainder is negated if sa (remainder takes the dividend's sign).
  - Write hi/lo. Multiply: hi = upper half, lo = lower half. Divide: lo = quotient, hi = remainder.
  - Pulse Done; return to IDLE.
- **Divide by zero:** no trap. hi = src_a as latched, lo = all ones, same latency as a normal divide.
- **MIN / -1 (DIV 0x80000000 / 0xFFFFFFFF):** lo = 0x80000000, hi = 0. This is the natural truncation result.
- **HiWre/LoWre:** honoured only in IDLE with Start low; each updates its register at the next edge. Both may be asserted together.
- **Start and HiWre/LoWre in the same IDLE cycle:** Start wins; the writes are dropped.
- **Start, HiWre, LoWre while Busy:** ignored; no queueing.
- **MdOp, src_a, src_b after the Start edge:** don't-care.
- **hi/lo during CALC:** hold their previous values, so a stale mfhi/mflo reads the old HI/LO.

## Timing
- Reset (sync, active-high):
  - State = IDLE; hi = 0, lo = 0, Busy = 0, Done = 0; counter and accumulators cleared.
  - Takes effect at the first posedge with Reset high, including mid-operation: the operation is aborted and no Done pulse is issued.
- Start sampled at edge E0:
  - Busy goes high after E0.
  - CALC occupies edges E1..E(WIDTH).
  - FIN commits at edge E(WIDTH+1): hi/lo update, Done = 1 and Busy = 0 during the following cycle.
  - Total: WIDTH+1 cycles busy (33 for WIDTH = 32).
- A new Start is accepted in the same cycle Done is high, since the state is IDLE.
- Done is high for exactly one cycle per completed operation.
- MTHI/MTLO: the write is visible on hi/lo one cycle after the sampling edge.
- Register-file write-back of mfhi/mflo happens on negedge, so hi/lo must be stable from posedge; hi and lo are driven directly from flops.

## Test plan
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001. Busy high 33 cycles; Done pulses once, in cycle 34 after Start.
- **MULT:** 0xFFFFFFFD (-3) × 7 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. Also MULT 0x80000000 × 0x80000000 -> hi = 0x40000000, lo = 0.
- **DIV:** -7 / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. **DIVU:** 100 / 7 -> lo = 14, hi = 2.
- **Divide corners:**
  - DIVU 0x12345678 / 0 -> hi = 0x12345678, lo = 0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- **Busy-time inputs:** Start and HiWre (src_a = 0xDEADBEEF) pulsed mid-CALC -> ignored; the original result lands with correct latency. Reset asserted at cycle 10 of an operation -> hi = lo = 0, Busy = 0, no Done pulse.
- **MTHI/MTLO:**
  - HiWre with src_a = 0xDEADBEEF in IDLE -> hi = 0xDEADBEEF next cycle, lo unchanged.
  - Start (MULTU 2 × 3) with LoWre in the same cycle -> LoWre dropped; lo = 6, hi = 0 after completion.
